// File: rtl/seq_mac_sequencer_if.sv
// Request/response channel between the dot-product sequencer and the sequential MAC unit.
interface seq_mac_sequencer_if #(
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int BW        = 5
);
    logic                               mac_valid_o;
    logic                               mac_ready_i;
    logic signed [K-1:0][MAX_WIDTH-1:0] mac_row_o;
    logic signed [K-1:0][MAX_WIDTH-1:0] mac_col_o;
    logic [31:0]                        mac_c_o;
    logic [BW-1:0]                      mac_bits_a_o;
    logic [BW-1:0]                      mac_bits_b_o;
    logic                               mac_valid_i;
    logic                               mac_ready_o;
    logic [31:0]                        mac_d_i;

    modport master (
        output mac_valid_o, mac_row_o, mac_col_o, mac_c_o, mac_bits_a_o, mac_bits_b_o, mac_ready_o,
        input  mac_ready_i, mac_valid_i, mac_d_i
    );

    modport slave (
        input  mac_valid_o, mac_row_o, mac_col_o, mac_c_o, mac_bits_a_o, mac_bits_b_o, mac_ready_o,
        output mac_ready_i, mac_valid_i, mac_d_i
    );
endinterface

// File: rtl/seq_mac_sequencer.sv
// Dot-product sequencer: streams operand vectors through one MAC, feeding each returned D
// back as the next C_in, and emits a single accumulated result per command.
module seq_mac_sequencer #(
    parameter int  K         = 2,
    parameter int  MAX_WIDTH = 16,
    parameter int  P         = 2,
    parameter int  LEN_W     = 8,
    localparam int BW        = $clog2(MAX_WIDTH / P) + 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic [LEN_W-1:0]                   cmd_len_i,
    input  logic [BW-1:0]                      cmd_bits_a_i,
    input  logic [BW-1:0]                      cmd_bits_b_i,
    input  logic [31:0]                        cmd_c_init_i,
    input  logic                               op_valid_i,
    output logic                               op_ready_o,
    input  logic signed [K-1:0][MAX_WIDTH-1:0] op_row_i,
    input  logic signed [K-1:0][MAX_WIDTH-1:0] op_col_i,
    seq_mac_sequencer_if.master                mac,
    output logic                               res_valid_o,
    input  logic                               res_ready_i,
    output logic [31:0]                        res_data_o,
    output logic                               busy_o,
    output logic                               err_o
);
    localparam int MAX_CHUNKS = MAX_WIDTH / P;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] FLUSH = 3'd5;

    logic [2:0]                         state_q, state_d;
    logic [31:0]                        acc_q, acc_d;
    logic [LEN_W-1:0]                   rem_q, rem_d;
    logic                               inflight_q, inflight_d;
    logic                               err_q, err_d;
    logic signed [K-1:0][MAX_WIDTH-1:0] row_q, row_d;
    logic signed [K-1:0][MAX_WIDTH-1:0] col_q, col_d;
    logic [BW-1:0]                      bits_a_q, bits_a_d;
    logic [BW-1:0]                      bits_b_q, bits_b_d;

    function automatic logic bits_illegal(input logic [BW-1:0] b);
        return (b == '0) || (int'(b) > MAX_CHUNKS);
    endfunction

    function automatic logic [BW-1:0] sat_bits(input logic [BW-1:0] b);
        return bits_illegal(b) ? BW'(MAX_CHUNKS) : b;
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        row_d      = row_q;
        col_d      = col_q;
        bits_a_d   = bits_a_q;
        bits_b_d   = bits_b_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    bits_a_d = sat_bits(cmd_bits_a_i);
                    bits_b_d = sat_bits(cmd_bits_b_i);
                    if (bits_illegal(cmd_bits_a_i) || bits_illegal(cmd_bits_b_i)) begin
                        err_d = 1'b1;
                    end
                    acc_d   = cmd_c_init_i;
                    rem_d   = cmd_len_i;
                    state_d = (cmd_len_i == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (op_valid_i) begin
                    row_d   = op_row_i;
                    col_d   = op_col_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mac.mac_ready_i) begin
                    inflight_d = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mac.mac_valid_i) begin
                    acc_d      = mac.mac_d_i;
                    inflight_d = 1'b0;
                    rem_d      = rem_q - LEN_W'(1);
                    state_d    = (rem_q == LEN_W'(1)) ? DONE : LOAD;
                end
            end
            DONE: begin
                if (res_ready_i) state_d = IDLE;
            end
            FLUSH: begin
                // The late D of an aborted job is swallowed here, never reaching acc.
                if (mac.mac_valid_i) begin
                    inflight_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mac.mac_valid_i && (state_q != WAIT) && (state_q != FLUSH)) begin
            err_d = 1'b1;
        end

        // Abort wins over every transition; a job accepted this very cycle still needs flushing.
        if (clear_i && (state_q != IDLE)) begin
            state_d = inflight_d ? FLUSH : IDLE;
        end
        if (clear_i) err_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            bits_a_q   <= '0;
            bits_b_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            row_q      <= row_d;
            col_q      <= col_d;
            bits_a_q   <= bits_a_d;
            bits_b_q   <= bits_b_d;
        end
    end

    assign cmd_ready_o      = (state_q == IDLE);
    assign op_ready_o       = (state_q == LOAD);
    assign mac.mac_valid_o  = (state_q == ISSUE);
    assign mac.mac_ready_o  = (state_q == WAIT) || (state_q == FLUSH);
    assign mac.mac_row_o    = row_q;
    assign mac.mac_col_o    = col_q;
    assign mac.mac_c_o      = acc_q;
    assign mac.mac_bits_a_o = bits_a_q;
    assign mac.mac_bits_b_o = bits_b_q;
    assign res_valid_o      = (state_q == DONE);
    assign res_data_o       = acc_q;
    assign busy_o           = (state_q != IDLE);
    assign err_o            = err_q;
endmodule

// File: tb/tb_seq_mac_sequencer.sv
// Bench for seq_mac_sequencer: table of dot-product commands against a behavioural MAC,
// plus hand-written abort, error and reset sequences.
module tb_seq_mac_sequencer;
    localparam int K     = 2;
    localparam int MW    = 16;
    localparam int P     = 2;
    localparam int LEN_W = 8;
    localparam int BW    = $clog2(MW / P) + 2;
    localparam int NENT  = 6;

    typedef logic signed [K-1:0][MW-1:0] vec_k_t;
    typedef struct {
        int          len;
        int          ba;
        int          bb;
        logic [31:0] cinit;
        logic [31:0] exp_res;
        int          eba;
        int          ebb;
        int          rd;
        int          lt;
        int          rs;
    } ent_t;
    typedef struct {
        vec_k_t row;
        vec_k_t col;
    } op_t;

    logic             clk_i       = 1'b0;
    logic             rst_ni      = 1'b0;
    logic             clear_i     = 1'b0;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [LEN_W-1:0] cmd_len_i    = '0;
    logic [BW-1:0]    cmd_bits_a_i = '0;
    logic [BW-1:0]    cmd_bits_b_i = '0;
    logic [31:0]      cmd_c_init_i = '0;
    logic             op_valid_i   = 1'b0;
    logic             op_ready_o;
    vec_k_t           op_row_i     = '0;
    vec_k_t           op_col_i     = '0;
    logic             res_valid_o;
    logic             res_ready_i  = 1'b0;
    logic [31:0]      res_data_o;
    logic             busy_o;
    logic             err_o;

    logic        m_ready = 1'b0;
    logic        m_valid = 1'b0;
    logic        spur    = 1'b0;
    logic [31:0] m_d     = '0;

    seq_mac_sequencer_if #(.K(K), .MAX_WIDTH(MW), .BW(BW)) mif ();

    assign mif.mac_ready_i = m_ready;
    assign mif.mac_valid_i = m_valid | spur;
    assign mif.mac_d_i     = m_d;

    seq_mac_sequencer #(.K(K), .MAX_WIDTH(MW), .P(P), .LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_len_i    (cmd_len_i),
        .cmd_bits_a_i (cmd_bits_a_i),
        .cmd_bits_b_i (cmd_bits_b_i),
        .cmd_c_init_i (cmd_c_init_i),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_row_i     (op_row_i),
        .op_col_i     (op_col_i),
        .mac          (mif),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_k_t mk(input int a0, input int a1);
        vec_k_t v;
        v[0] = a0[MW-1:0];
        v[1] = a1[MW-1:0];
        return v;
    endfunction

    function automatic ent_t ent(input int len, input int ba, input int bb,
                                 input logic [31:0] cinit, input logic [31:0] exp_res,
                                 input int eba, input int ebb, input int rd, input int lt, input int rs);
        ent_t e;
        e.len = len; e.ba = ba; e.bb = bb; e.cinit = cinit; e.exp_res = exp_res;
        e.eba = eba; e.ebb = ebb; e.rd = rd; e.lt = lt; e.rs = rs;
        return e;
    endfunction

    // cycle bookkeeping shared by the model and the checks
    int cyc = 0, t_cmd = 0, t_macd = 0, mac_hs = 0, oprdy_cyc = 0;
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (cmd_valid_i && cmd_ready_o) t_cmd <= cyc;
        if (mif.mac_valid_i && mif.mac_ready_o) t_macd <= cyc;
        if (mif.mac_valid_o && mif.mac_ready_i) mac_hs <= mac_hs + 1;
        if (op_ready_o) oprdy_cyc <= oprdy_cyc + 1;
    end

    ent_t        tbl[NENT];
    vec_k_t      tr[NENT][3];
    vec_k_t      tc[NENT][3];
    op_t         op_q[$];
    logic [31:0] res_q[$];

    bit          mac_en    = 1'b1;
    bit          force_en  = 1'b0;
    logic [31:0] force_d   = '0;
    logic [31:0] exp_cinit = '0;
    int          exp_ba = 0, exp_bb = 0, rdy_dly = 0, lat = 1;

    // Behavioural MAC: D = C + sum(row[i]*col[i]), with programmable accept delay and latency.
    initial begin : mac_model
        op_t         e;
        vec_k_t      r0, c0;
        logic [31:0] c0v, d, acc_m;
        int          last_tcmd, n, a, b;
        last_tcmd = -1;
        acc_m     = '0;
        forever begin
            @(negedge clk_i);
            if (mac_en && rst_ni && mif.mac_valid_o) begin
                if (t_cmd != last_tcmd) begin
                    last_tcmd = t_cmd;
                    acc_m     = exp_cinit;
                    chk("issue_latency", cyc - t_cmd, 2);
                end
                r0  = mif.mac_row_o;
                c0  = mif.mac_col_o;
                c0v = mif.mac_c_o;
                chk("mac_c", c0v, acc_m);
                chk("mac_bits_a", 32'(mif.mac_bits_a_o), exp_ba);
                chk("mac_bits_b", 32'(mif.mac_bits_b_o), exp_bb);
                if (op_q.size() > 0) begin
                    e = op_q.pop_front();
                    chk("mac_row", r0, e.row);
                    chk("mac_col", c0, e.col);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL mac_job: unexpected job row=0x%0h, expected none", r0);
                end
                repeat (rdy_dly) begin
                    @(negedge clk_i);
                    chk("hold_valid", mif.mac_valid_o, 1);
                    chk("hold_row", mif.mac_row_o, r0);
                    chk("hold_col", mif.mac_col_o, c0);
                    chk("hold_c", mif.mac_c_o, c0v);
                end
                m_ready = 1'b1;
                @(negedge clk_i);
                m_ready = 1'b0;
                d = c0v;
                for (int i = 0; i < K; i++) begin
                    a = $signed(r0[i]);
                    b = $signed(c0[i]);
                    d = d + a * b;
                end
                repeat (lat - 1) @(negedge clk_i);
                if (force_en) d = force_d;
                m_d     = d;
                m_valid = 1'b1;
                n = 0;
                while (!mif.mac_ready_o && n < 100) begin
                    @(negedge clk_i);
                    n++;
                end
                if (n >= 100) begin
                    checks++;
                    errors++;
                    $display("FAIL mac_return: mac_ready_o stayed 0, expected 1");
                end
                @(negedge clk_i);
                m_valid = 1'b0;
                acc_m   = d;
            end
        end
    end

    task automatic run_entry(input int idx);
        ent_t        v;
        op_t         o;
        int          n, mh0, oc0;
        logic [31:0] hold, exp;
        v = tbl[idx];
        mh0 = mac_hs;
        oc0 = oprdy_cyc;
        rdy_dly   = v.rd;
        lat       = v.lt;
        exp_ba    = v.eba;
        exp_bb    = v.ebb;
        exp_cinit = v.cinit;
        @(negedge clk_i);
        cmd_valid_i  = 1'b1;
        cmd_len_i    = LEN_W'(v.len);
        cmd_bits_a_i = BW'(v.ba);
        cmd_bits_b_i = BW'(v.bb);
        cmd_c_init_i = v.cinit;
        res_q.push_back(v.exp_res);
        if (v.len > 0) begin
            op_valid_i = 1'b1;
            op_row_i   = tr[idx][0];
            op_col_i   = tc[idx][0];
            o.row = tr[idx][0];
            o.col = tc[idx][0];
            op_q.push_back(o);
        end
        chk("cmd_ready_idle", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                op_valid_i = 1'b1;
                op_row_i   = tr[idx][i];
                op_col_i   = tc[idx][i];
                o.row = tr[idx][i];
                o.col = tc[idx][i];
                op_q.push_back(o);
            end
            n = 0;
            while (!op_ready_o && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL op_ready_timeout: entry %0d vec %0d op_ready_o=0, expected 1", idx, i);
            end
            @(negedge clk_i);
            op_valid_i = 1'b0;
        end
        n = 0;
        while (!res_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL res_timeout: entry %0d res_valid_o=0, expected 1", idx);
        end else begin
            chk("res_latency", cyc - ((v.len == 0) ? t_cmd : t_macd), 1);
            hold = res_data_o;
            repeat (v.rs) begin
                @(negedge clk_i);
                chk("res_valid_hold", res_valid_o, 1);
                chk("res_data_hold", res_data_o, hold);
            end
            exp = res_q.pop_front();
            chk("res_data", res_data_o, exp);
            res_ready_i = 1'b1;
            @(negedge clk_i);
            res_ready_i = 1'b0;
        end
        chk("mac_jobs", mac_hs - mh0, v.len);
        if (v.len == 0) chk("no_op_ready", oprdy_cyc - oc0, 0);
        chk("idle_after", busy_o, 0);
        chk("res_dropped", res_valid_o, 0);
    endtask

    initial begin : main
        op_t o;
        int  n;

        tbl[0] = ent(2, 4, 4, 32'd10, 32'd15, 4, 4, 0, 1, 0);
        tr[0][0] = mk(3, -2); tc[0][0] = mk(5, 7);
        tr[0][1] = mk(1, 1);  tc[0][1] = mk(2, 2);
        tbl[1] = ent(0, 4, 4, 32'h1234, 32'h1234, 4, 4, 0, 1, 0);
        tbl[2] = ent(1, 2, 3, 32'd100, 32'd107, 2, 3, 5, 9, 3);
        tr[2][0] = mk(5, 6);  tc[2][0] = mk(-1, 2);
        tbl[3] = ent(3, 8, 8, 32'hFFFF_FFFF, 32'd22, 8, 8, 1, 2, 1);
        tr[3][0] = mk(1, 0);  tc[3][0] = mk(1, 0);
        tr[3][1] = mk(-1, 0); tc[3][1] = mk(1, 0);
        tr[3][2] = mk(2, 3);  tc[3][2] = mk(4, 5);
        tbl[4] = ent(1, 0, 9, 32'd0, 32'd2, 8, 8, 0, 1, 0);
        tr[4][0] = mk(-3, 4); tc[4][0] = mk(2, 2);
        tbl[5] = ent(1, 4, 4, 32'd7, 32'd8, 4, 4, 0, 1, 0);
        tr[5][0] = mk(1, 0);  tc[5][0] = mk(1, 0);

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_op_ready", op_ready_o, 0);
        chk("rst_mac_valid", mif.mac_valid_o, 0);
        chk("rst_mac_ready", mif.mac_ready_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mac_c", mif.mac_c_o, 0);
        chk("rst_mac_bits_a", 32'(mif.mac_bits_a_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_cmd_ready", cmd_ready_o, 1);

        for (int i = 0; i < 4; i++) run_entry(i);
        chk("err_clean", err_o, 0);
        run_entry(4);
        chk("err_bits", err_o, 1);

        // error flag: clear, spurious D in IDLE, clear again
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("err_cleared", err_o, 0);
        spur = 1'b1;
        @(negedge clk_i);
        spur = 1'b0;
        chk("err_spurious", err_o, 1);
        chk("spur_idle", busy_o, 0);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("err_cleared2", err_o, 0);

        // abort with a job in flight; the late D must be flushed
        rdy_dly = 0; lat = 12; force_en = 1'b1; force_d = 32'h0000_FFFF;
        exp_ba = 4; exp_bb = 4; exp_cinit = 32'd3;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_len_i = 8'd1; cmd_bits_a_i = 5'd4; cmd_bits_b_i = 5'd4;
        cmd_c_init_i = 32'd3;
        op_valid_i = 1'b1; op_row_i = mk(1, 1); op_col_i = mk(1, 1);
        o.row = mk(1, 1); o.col = mk(1, 1);
        op_q.push_back(o);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        op_valid_i = 1'b0;
        n = 0;
        while (!mif.mac_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_reached", mif.mac_ready_o, 1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("flush_busy", busy_o, 1);
        chk("flush_mac_ready", mif.mac_ready_o, 1);
        chk("flush_mac_valid", mif.mac_valid_o, 0);
        chk("flush_cmd_ready", cmd_ready_o, 0);
        n = 0;
        while (busy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("flush_to_idle", busy_o, 0);
        chk("flush_no_res", res_valid_o, 0);
        chk("flush_no_err", err_o, 0);
        @(negedge clk_i);
        force_en = 1'b0;
        run_entry(5);

        // asynchronous reset while a job is being offered
        mac_en = 1'b0;
        exp_ba = 4; exp_bb = 4;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_len_i = 8'd1; cmd_c_init_i = 32'd5;
        op_valid_i = 1'b1; op_row_i = mk(2, 2); op_col_i = mk(2, 2);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        op_valid_i = 1'b0;
        chk("pre_rst_issue", mif.mac_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_mac_valid", mif.mac_valid_o, 0);
        chk("arst_res_valid", res_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_mac_row", mif.mac_row_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("arst_release_cmd_ready", cmd_ready_o, 1);
        chk("arst_release_op_ready", op_ready_o, 0);
        mac_en = 1'b1;
        run_entry(0);

        chk("res_q_drained", res_q.size(), 0);
        chk("op_q_drained", op_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/seq_mac_sequencer.md
Name: seq_mac_sequencer

Overview:
Initiator for the sequential multiply-accumulate unit. It accepts a dot-product command and pulls K-wide operand vectors from an operand stream. Each vector is issued to the MAC unit over its valid/ready request channel, and each returned D is collected and fed back as C_in for the next vector. After cmd_len vectors, one 32-bit result is emitted, so an arbitrary-length dot product runs on a single MAC instance.

Parameters:
K, 2, operand vector width in elements; must match the MAC unit.
MAX_WIDTH, 16, element container width in bits.
P, 2, MAC digit width in bits; bit sizes are expressed in P-bit chunks.
LEN_W, 8, width of the command length field.
BW (localparam), $clog2(MAX_WIDTH/P)+2, width of the bit-size fields.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous abort; returns to IDLE via FLUSH
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready; high only in IDLE
cmd_len_i  in  LEN_W  number of operand vectors to accumulate
cmd_bits_a_i  in  BW  row element size in P-bit chunks, legal 1..MAX_WIDTH/P
cmd_bits_b_i  in  BW  column element size in P-bit chunks
cmd_c_init_i  in  32  initial accumulator value
op_valid_i  in  1  operand vector valid
op_ready_o  out  1  operand ready; high only in LOAD
op_row_i  in  K x MAX_WIDTH signed  row elements
op_col_i  in  K x MAX_WIDTH signed  column elements
mac_valid_o  out  1  request to MAC
mac_ready_i  in  1  MAC ready_in
mac_row_o / mac_col_o  out  K x MAX_WIDTH  registered operands
mac_c_o  out  32  accumulator fed to MAC C_in
mac_bits_a_o / mac_bits_b_o  out  BW  registered bit sizes
mac_valid_i  in  1  MAC valid_out
mac_ready_o  out  1  MAC ready_out; high in WAIT and FLUSH
mac_d_i  in  32  MAC result D
res_valid_o  out  1  final result valid
res_ready_i  in  1  result ready
res_data_o  out  32  final accumulated result
busy_o  out  1  state != IDLE
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async): state=IDLE; all valid outputs 0; acc=0; operand and bit-size regs 0; remaining=0; inflight=0; err_o=0. cmd_ready_o=1 after reset.
- FSM states: IDLE, LOAD, ISSUE, WAIT, DONE, FLUSH.
- IDLE: on cmd_valid_i, capture the command into registers.
  - Bit sizes equal to 0 or greater than MAX_WIDTH/P are replaced by MAX_WIDTH/P, and err_o is set.
  - acc <= cmd_c_init_i; remaining <= cmd_len_i.
  - If cmd_len_i==0, go to DONE; otherwise go to LOAD.
- LOAD: op_ready_o=1. On op_valid_i, register the row and column and go to ISSUE.
- ISSUE: mac_valid_o=1.
  - mac_row/col/c/bits stay stable while mac_valid_o & ~mac_ready_i.
  - On mac_ready_i: inflight<=1, go to WAIT.
- WAIT: mac_ready_o=1. On mac_valid_i:
  - acc <= mac_d_i; inflight<=0; remaining<=remaining-1.
  - If remaining==1, go to DONE; otherwise go to LOAD.
- DONE: res_valid_o=1, res_data_o=acc, held stable until res_ready_i. On the handshake, go to IDLE.
- Latency: cmd handshake at cycle t. With op_valid_i already high, mac_valid_o rises at t+2. After the final mac_valid_i at cycle u, res_valid_o rises at u+1.
- At most one MAC job is outstanding. The C_in of job i+1 is the D of job i.
- mac_valid_i outside WAIT/FLUSH: ignored, D is discarded, err_o set.
- clear_i has priority over all transitions:
  - From ISSUE with mac_ready_i in the same cycle, the job counts as issued.
  - If inflight, go to FLUSH, where mac_ready_o=1, mac_valid_o=0 and the next mac_valid_i is absorbed and discarded, then go to IDLE.
  - Otherwise go to IDLE directly.
  - clear_i in IDLE is a no-op. clear_i also clears err_o.
- Simultaneous events:
  - cmd_valid_i in a non-IDLE state is not accepted.
  - res_ready_i with res_valid_o=0 has no effect.
- Arithmetic: acc is 32-bit and wraps. The sequencer performs no addition; all arithmetic is done by the MAC.
- Reset mid-operation aborts immediately. The MAC shares rst_ni, so no flush is needed.

Test Plan:
- K=2, bits 4/4, c_init=10, len=2; ops {3,-2}·{5,7} then {1,1}·{2,2}; behavioural MAC returns C+dot -> mac_c_o 10 then 11; res_data_o=15; exactly 2 MAC handshakes.
- len=0, c_init=0x1234 -> no op_ready_o pulse, no mac_valid_o; res_valid_o at t+1 with 0x1234.
- MAC holds mac_ready_i low for 5 cycles, then returns D after 9 cycles; res_ready_i low for 3 cycles -> mac_* and res_data_o remain stable throughout; single result delivered.
- clear_i asserted in WAIT with a job inflight -> FLUSH; late D=0xFFFF is discarded; next command c_init=7, len=1, {1,0}·{1,0} -> res=8.
- Spurious mac_valid_i in IDLE, and cmd_bits_a_i=0 -> err_o=1, bits issued as 8; err_o clears on clear_i.
- rst_ni pulsed low mid-ISSUE -> all valids 0 asynchronously; state IDLE; cmd_ready_o=1 after release.
